// File: rtl/glyph_banner_pkg.sv
// Shared types and constants for the glyph banner sequencer.
package glyph_banner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REVEAL,
        ST_HOLD,
        ST_BLINK,
        ST_CLEAR
    } banner_state_t;

    typedef logic [9:0] coord_t;

    localparam int GLYPH_W_PX = 32;
    localparam int GLYPH_H_PX = 40;

endpackage

// File: rtl/glyph_banner_if.sv
// Bus between game-state logic / glyph renderers and the banner sequencer.
interface glyph_banner_if #(
    parameter int N_GLYPH = 8
);
    logic                          frame_tick;
    logic                          start;
    logic                          abort;
    glyph_banner_pkg::coord_t      x0_base;
    glyph_banner_pkg::coord_t      y0_base;
    logic [N_GLYPH-1:0]            glyph_en;
    logic [10*N_GLYPH-1:0]         glyph_x0;
    glyph_banner_pkg::coord_t      glyph_y0;
    logic                          busy;
    logic                          done;

    modport master (
        output frame_tick, start, abort, x0_base, y0_base,
        input  glyph_en, glyph_x0, glyph_y0, busy, done
    );

    modport slave (
        input  frame_tick, start, abort, x0_base, y0_base,
        output glyph_en, glyph_x0, glyph_y0, busy, done
    );
endinterface

// File: rtl/banner_frame_cnt.sv
// Loadable frame-tick down-counter; zero marks the tick on which the current period ends.
module banner_frame_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (frame_tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/glyph_banner_ctrl.sv
// Typewriter-style banner sequencer: reveal, hold, optional blink, clear.
// Blink phase is compiled only when GLYPH_BANNER_BLINK_EN is defined.
module glyph_banner_ctrl
    import glyph_banner_pkg::*;
#(
    parameter int N_GLYPH       = 8,
    parameter int GLYPH_W       = GLYPH_W_PX,
    parameter int GLYPH_GAP     = 8,
    parameter int REVEAL_FRAMES = 15,
    parameter int HOLD_FRAMES   = 120,
    parameter int BLINK_FRAMES  = 30,
    parameter int BLINK_COUNT   = 3
) (
    input  logic            clk,
    input  logic            rst,
    glyph_banner_if.slave   bus
);
    localparam int PITCH = GLYPH_W + GLYPH_GAP;
    localparam int MAX_RH = (REVEAL_FRAMES > HOLD_FRAMES) ? REVEAL_FRAMES : HOLD_FRAMES;
    localparam int MAX_P  = (MAX_RH > BLINK_FRAMES) ? MAX_RH : BLINK_FRAMES;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    banner_state_t         state_q, state_d;
    logic [N_GLYPH-1:0]    en_q, en_d;
    logic [10*N_GLYPH-1:0] x0_q, x0_d;
    coord_t                y0_q, y0_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_val;
    logic                  cnt_zero;
    logic                  fire;
    logic [N_GLYPH:0]      en_shift;
    logic                  do_clear;

`ifdef GLYPH_BANNER_BLINK_EN
    localparam int BLINK_LAST = 2 * BLINK_COUNT - 1;
    localparam int BC_W       = $clog2(BLINK_LAST + 1);
    logic [BC_W-1:0] blink_q, blink_d;
`endif

    banner_frame_cnt #(.W(CNT_W)) u_frame_cnt (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (bus.frame_tick),
        .load       (cnt_load),
        .load_val   (cnt_val),
        .zero       (cnt_zero)
    );

    // A period ends on the frame tick seen while the counter sits at zero.
    assign fire     = bus.frame_tick && cnt_zero;
    assign en_shift = {en_q, 1'b1};

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        do_clear = 1'b0;
`ifdef GLYPH_BANNER_BLINK_EN
        blink_d  = blink_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < N_GLYPH; i++) begin
                        x0_d[10*i +: 10] = bus.x0_base + coord_t'(i * PITCH);
                    end
                    y0_d     = bus.y0_base;
                    busy_d   = 1'b1;
                    state_d  = ST_REVEAL;
                    cnt_load = 1'b1;
                end
            end
            ST_REVEAL: begin
                if (fire) begin
                    en_d     = en_shift[N_GLYPH-1:0];
                    cnt_load = 1'b1;
                    if (&en_shift[N_GLYPH-1:0]) begin
                        state_d = ST_HOLD;
                        cnt_val = CNT_W'(HOLD_FRAMES - 1);
                    end else begin
                        cnt_val = CNT_W'(REVEAL_FRAMES - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (fire) begin
`ifdef GLYPH_BANNER_BLINK_EN
                    en_d     = '0;
                    state_d  = ST_BLINK;
                    blink_d  = '0;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(BLINK_FRAMES - 1);
`else
                    do_clear = 1'b1;
`endif
                end
            end
`ifdef GLYPH_BANNER_BLINK_EN
            ST_BLINK: begin
                if (fire) begin
                    if (blink_q == BC_W'(BLINK_LAST)) begin
                        do_clear = 1'b1;
                    end else begin
                        en_d     = ~en_q;
                        blink_d  = blink_q + 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(BLINK_FRAMES - 1);
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clearing is folded into the ending tick so done and busy fall together.
        if (do_clear) begin
            en_d    = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
        end

        if (bus.abort && (state_q != ST_IDLE)) begin
            en_d    = '0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GLYPH_BANNER_BLINK_EN
            blink_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GLYPH_BANNER_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    assign bus.glyph_en = en_q;
    assign bus.glyph_x0 = x0_q;
    assign bus.glyph_y0 = y0_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_glyph_banner_ctrl.sv
// Randomized and directed bench for glyph_banner_ctrl against a frame-count schedule model.
module tb_glyph_banner_ctrl;
    localparam int N   = 4;
    localparam int RF  = 2;
    localparam int HF  = 3;
    localparam int BF  = 2;
    localparam int BC  = 2;
    localparam int T_H = 1 + (N - 1) * RF + HF;
`ifdef GLYPH_BANNER_BLINK_EN
    localparam int T_END = T_H + 2 * BC * BF;
`else
    localparam int T_END = T_H;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    glyph_banner_if #(.N_GLYPH(N)) bus ();

    glyph_banner_ctrl #(
        .N_GLYPH(N), .GLYPH_W(32), .GLYPH_GAP(8),
        .REVEAL_FRAMES(RF), .HOLD_FRAMES(HF),
        .BLINK_FRAMES(BF), .BLINK_COUNT(BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    bit          busy_m = 0;
    bit          done_m = 0;
    int          t_m    = 0;
    logic [39:0] x0_m   = '0;
    logic [9:0]  y0_m   = '0;

    // Expected enables as a function of ticks since acceptance.
    function automatic logic [N-1:0] enAt(input int t, input bit busy);
        int k;
        int j;
        if (!busy || t == 0) return '0;
        if (t < T_H) begin
            k = (t - 1) / RF + 1;
            if (k > N) k = N;
            return N'((1 << k) - 1);
        end
        j = (t - T_H) / BF;
        return (j % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t_m);
        end
    endtask

    task automatic checkAll();
        checkOutput("glyph_en", 64'(bus.glyph_en), 64'(enAt(t_m, busy_m)));
        checkOutput("busy",     64'(bus.busy),     64'(busy_m));
        checkOutput("done",     64'(bus.done),     64'(done_m));
        checkOutput("glyph_x0", 64'(bus.glyph_x0), 64'(x0_m));
        checkOutput("glyph_y0", 64'(bus.glyph_y0), 64'(y0_m));
    endtask

    // One clock: drive inputs, advance the model on the edge, then check.
    task automatic applyStimulus(input bit s, input bit a, input bit f);
        @(negedge clk);
        bus.start      = s;
        bus.abort      = a;
        bus.frame_tick = f;
        @(posedge clk);
        done_m = 0;
        if (!busy_m) begin
            if (s) begin
                busy_m = 1;
                t_m    = 0;
                y0_m   = bus.y0_base;
                for (int i = 0; i < N; i++) x0_m[10*i +: 10] = 10'(int'(bus.x0_base) + i * 40);
            end
        end else if (a) begin
            busy_m = 0;
        end else if (f) begin
            t_m++;
            if (t_m == T_END) begin
                busy_m = 0;
                done_m = 1;
            end
        end
        #1;
        checkAll();
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 1);
            applyStimulus(0, 0, 0);
        end
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.frame_tick = 0;
        bus.x0_base = '0; bus.y0_base = '0;
        rst = 1;
        #12;
        checkOutput("reset_en",   64'(bus.glyph_en), 64'(0));
        checkOutput("reset_busy", 64'(bus.busy),     64'(0));
        checkOutput("reset_done", 64'(bus.done),     64'(0));
        checkOutput("reset_x0",   64'(bus.glyph_x0), 64'(0));
        @(negedge clk);
        rst = 0;
        applyStimulus(0, 0, 1);

        // Basic run with explicit origin values.
        bus.x0_base = 10'd100; bus.y0_base = 10'd200;
        applyStimulus(1, 0, 1);
        checkOutput("basic_x3", 64'(bus.glyph_x0[39:30]), 64'(220));
        checkOutput("basic_x2", 64'(bus.glyph_x0[29:20]), 64'(180));
        checkOutput("basic_x1", 64'(bus.glyph_x0[19:10]), 64'(140));
        checkOutput("basic_x0", 64'(bus.glyph_x0[9:0]),   64'(100));
        checkOutput("basic_y0", 64'(bus.glyph_y0),        64'(200));
        checkOutput("basic_en0", 64'(bus.glyph_en),       64'(0));
        runTicks(7);
        checkOutput("basic_en_t7", 64'(bus.glyph_en), 64'(4'hF));
        runTicks(T_END - 7);
        checkOutput("basic_idle", 64'(bus.busy), 64'(0));

        // Origin wrap-around.
        bus.x0_base = 10'd1000;
        applyStimulus(1, 0, 0);
        checkOutput("wrap_x1", 64'(bus.glyph_x0[19:10]), 64'(16));
        checkOutput("wrap_x2", 64'(bus.glyph_x0[29:20]), 64'(56));
        checkOutput("wrap_x3", 64'(bus.glyph_x0[39:30]), 64'(96));
        runTicks(T_END);

        // Start during REVEAL is ignored.
        bus.x0_base = 10'd100;
        applyStimulus(1, 0, 0);
        runTicks(4);
        bus.x0_base = 10'd300;
        applyStimulus(1, 0, 0);
        checkOutput("ignore_x0", 64'(bus.glyph_x0[9:0]), 64'(100));
        runTicks(T_END - 4);

        // Abort coincident with tick and start, then restart.
        bus.x0_base = 10'd50;
        applyStimulus(1, 0, 0);
        runTicks(5);
        applyStimulus(1, 1, 1);
        checkOutput("abort_en",   64'(bus.glyph_en), 64'(0));
        checkOutput("abort_busy", 64'(bus.busy),     64'(0));
        checkOutput("abort_done", 64'(bus.done),     64'(0));
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("restart_en", 64'(bus.glyph_en), 64'(4'h1));
        runTicks(T_END - 1);

        // Asynchronous reset in the middle of the late phase.
        applyStimulus(1, 0, 0);
        runTicks(T_END - 2);
        #3;
        rst = 1;
        #1;
        checkOutput("arst_en",   64'(bus.glyph_en), 64'(0));
        checkOutput("arst_busy", 64'(bus.busy),     64'(0));
        checkOutput("arst_x0",   64'(bus.glyph_x0), 64'(0));
        checkOutput("arst_y0",   64'(bus.glyph_y0), 64'(0));
        busy_m = 0; done_m = 0; t_m = 0; x0_m = '0; y0_m = '0;
        @(negedge clk);
        rst = 0;
        runTicks(3);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.x0_base = 10'($urandom);
            bus.y0_base = 10'($urandom);
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 63) == 0,
                          $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/glyph_banner_ctrl.md
# glyph_banner_ctrl

Sequencer that drives a row of 32x40 letter-glyph renderers to show a short on-screen message such as "GAME OVER". It sets each glyph slot's origin and enable. Glyphs are revealed one at a time in typewriter style, the full message is held, optionally blinked, then cleared. All sequencing is paced by the display's per-frame tick, so the picture never changes mid-frame. The block sits between game-state logic (start/abort) and the glyph renderer instances that feed the pixel mux.

## Interface
- `N_GLYPH`, 8: number of glyph slots driven.
- `GLYPH_W`, 32: glyph width in pixels.
- `GLYPH_GAP`, 8: horizontal gap between glyphs in pixels.
- `REVEAL_FRAMES`, 15: frames between successive glyph reveals (>=1).
- `HOLD_FRAMES`, 120: frames the full message is held (>=1).
- `BLINK_FRAMES`, 30: frames per blink half-period (>=1).
- `BLINK_COUNT`, 3: number of off/on blink pairs (>=1).

- `clk`, in, 1: pixel clock. One clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse at start of vertical blank.
- `start`, in, 1: level sampled each cycle; accepted only in IDLE.
- `abort`, in, 1: return to IDLE immediately and blank all glyphs.
- `x0_base`, in, 10: x origin of slot 0.
- `y0_base`, in, 10: y origin of the row.
- `glyph_en`, out, N_GLYPH: per-slot enable to the renderers.
- `glyph_x0`, out, 10*N_GLYPH: packed per-slot x origin; slot i occupies bits [10i+9:10i].
- `glyph_y0`, out, 10: common y origin.
- `busy`, out, 1: high from start acceptance until done.
- `done`, out, 1: one-cycle pulse when the sequence completes normally.

## Operation
- States: IDLE, REVEAL, HOLD, BLINK, CLEAR.
- IDLE, start=1: latch `glyph_y0`=`y0_base` and `glyph_x0[i]`=`x0_base`+i*(`GLYPH_W`+`GLYPH_GAP`), truncated to 10 bits (wraps mod 1024, not clamped). Then go to REVEAL and set busy=1. Origins hold until the next accepted start.
- Count frame_ticks after acceptance as t=1,2,… A tick coincident with the acceptance cycle is not counted.
- REVEAL: slot k enables at t=1+k*REVEAL_FRAMES. Enables are cumulative. After slot N-1 enables, go to HOLD.
- HOLD ends at t=T_h, where T_h=1+(N_GLYPH-1)*REVEAL_FRAMES+HOLD_FRAMES.
- BLINK (macro on): at T_h all enables go to 0. At T_h+j*BLINK_FRAMES, all enables toggle for j=1..2*BLINK_COUNT-1, so the last toggle turns them on. At T_h+2*BLINK_COUNT*BLINK_FRAMES, enter CLEAR.
- CLEAR: enables go to 0, done=1 for one cycle, busy=0, go to IDLE. All of this happens on the same edge.
- start while busy: ignored. start held high in IDLE: restarts on the cycle after done.
- abort in any non-IDLE state: next edge gives glyph_en=0, busy=0, state IDLE, and no done. abort wins over a coincident start or frame_tick. abort in IDLE has no effect.
- Reset values: state IDLE, glyph_en=0, glyph_x0=0, glyph_y0=0, busy=0, done=0, all counters 0.
- Asserting rst mid-sequence forces reset values immediately, asynchronously.

## Timing
- All outputs are registered. A change triggered by frame_tick sampled high at edge E is visible after E.
- glyph_en changes only on frame_tick edges, abort, or reset.
- start acceptance → busy high 1 cycle later.
- done coincides with busy falling. There is no done on abort.

## Configuration
- `GLYPH_BANNER_BLINK_EN` defined: the BLINK state exists as described.
- Undefined: HOLD goes to CLEAR at T_h. Enables drop and done pulses at T_h. BLINK logic and counters are not compiled.

## Structure
- Package `glyph_banner_pkg` contains:
  - state enum typedef;
  - `coord_t` (10-bit) typedef;
  - constants `GLYPH_W_PX`=32 and `GLYPH_H_PX`=40.
- One sub-module, `banner_frame_cnt`: a loadable down-counter advanced by frame_tick, with a zero flag. It is shared across the REVEAL, HOLD and BLINK periods.

## Test plan
Config for all scenarios: N=4, REVEAL=2, HOLD=3, BLINK_FRAMES=2, BLINK_COUNT=2.
- Basic run, macro on: x0_base=100, y0_base=200, start → glyph_x0={220,180,140,100}, glyph_y0=200. Enables 0001, 0011, 0111, 1111 at t=1,3,5,7. 0000 at t=10, 1111 at 12, 0000 at 14, 1111 at 16. At t=18: 0000, done pulse, busy falls.
- Macro off, same stimulus: 1111 at t=7, then at t=10 enables 0000 and done pulses. No toggling in between.
- Wrap: x0_base=1000 → slot1 x0=16, slot2 x0=56, slot3 x0=96.
- start during REVEAL at t=4 → ignored. Origins unchanged, schedule unchanged.
- abort at t=6 coincident with frame_tick and start → next cycle glyph_en=0, busy=0, no done. A following start restarts from t=1.
- rst asserted mid-BLINK without a clock edge → all outputs 0 immediately. After release, stays in IDLE until start.
